// File: rtl/strobe_gpio_monitor.sv
`default_nettype none
// ============================================================================
// Module   : strobe_gpio_monitor
// Brief    : Receive side of a GPIO heartbeat strobe. Synchronises, debounces
//            and edge-detects the pin, then measures period and high time and
//            flags loss of strobe.
// Revision : 1.0
// ============================================================================
module strobe_gpio_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int PERIOD_W        = 32,
  parameter int TIMEOUT_CYCLES  = 200000000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                gpio_in_i,
  output logic                level_o,
  output logic                rise_pulse_o,
  output logic                fall_pulse_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic [PERIOD_W-1:0] high_time_o,
  output logic                overflow_o,
  output logic                alive_o,
  output logic                timeout_o
);

  localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0]   c_DCNT_LAST    = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] c_TIMEOUT_LAST = PERIOD_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [PERIOD_W-1:0]    rcnt_q, rcnt_d;
  logic [PERIOD_W-1:0]    hcnt_q, hcnt_d;
  logic [PERIOD_W-1:0]    period_q, period_d;
  logic [PERIOD_W-1:0]    high_q, high_d;
  logic                   pv_q, pv_d;
  logic                   ovf_q, ovf_d;
  logic                   alive_q, alive_d;
  logic                   to_q, to_d;
  logic                   armed_q, armed_d;

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sync_s = sync_q[SYNC_STAGES-1];

  // The level only flips after DEBOUNCE_CYCLES back-to-back disagreeing samples.
  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    if (sync_s != level_q) begin
      if (dcnt_q == c_DCNT_LAST) level_d = sync_s;
      else                       dcnt_d  = dcnt_q + 1'b1;
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_comb begin
    rcnt_d   = rise_q ? '0 : sat_inc(rcnt_q);
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    pv_d     = 1'b0;
    ovf_d    = ovf_q;
    alive_d  = alive_q;
    to_d     = to_q;
    armed_d  = armed_q;
    if (rise_q)       hcnt_d = '0;
    else if (level_q) hcnt_d = sat_inc(hcnt_q);
    // A rise in the same cycle as the timeout condition suppresses the timeout.
    if (rise_q) begin
      armed_d = 1'b1;
      to_d    = 1'b0;
      if (armed_q) begin
        period_d = sat_inc(rcnt_q);
        pv_d     = 1'b1;
        ovf_d    = &rcnt_q;
        alive_d  = 1'b1;
      end
    end else if (armed_q && (rcnt_q == c_TIMEOUT_LAST)) begin
      to_d    = 1'b1;
      alive_d = 1'b0;
    end
    if (fall_q && armed_q) high_d = sat_inc(hcnt_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      dcnt_q   <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      rcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      pv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      alive_q  <= 1'b0;
      to_q     <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], gpio_in_i};
      dcnt_q   <= dcnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rcnt_q   <= rcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      pv_q     <= pv_d;
      ovf_q    <= ovf_d;
      alive_q  <= alive_d;
      to_q     <= to_d;
      armed_q  <= armed_d;
    end
  end

  assign level_o        = level_q;
  assign rise_pulse_o   = rise_q;
  assign fall_pulse_o   = fall_q;
  assign period_o       = period_q;
  assign period_valid_o = pv_q;
  assign high_time_o    = high_q;
  assign overflow_o     = ovf_q;
  assign alive_o        = alive_q;
  assign timeout_o      = to_q;

endmodule
`default_nettype wire
